// File: rtl/sw_led_mode_ctrl.sv
// Synchronised, debounced switch-code decoder driving one-hot LEDs in STATIC/BLINK/CHASE modes.
// Define SWLED_CHASE_EN to build the CHASE mode; without it the mode button toggles STATIC/BLINK.
module sw_led_mode_ctrl #(
  parameter int SW_W            = 2,
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int BLINK_DIV       = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SW_W-1:0]      sw,
  input  logic                 btn_mode,
  output logic [2**SW_W-1:0]   led,
  output logic [1:0]           mode,
  output logic [SW_W-1:0]      sw_stable,
  output logic                 code_change
);

  localparam int LED_W = 2**SW_W;
  localparam int NB    = SW_W + 1;
  localparam int CW    = $clog2(DEBOUNCE_CYCLES);
  localparam int PW    = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    M_STATIC = 2'b00,
    M_BLINK  = 2'b01,
    M_CHASE  = 2'b10
  } mode_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    stable;
  logic [CW-1:0]    db_cnt [NB];

  logic             btn_stable;
  logic             btn_prev;
  logic             btn_rise;
  logic [SW_W-1:0]  sw_prev;
  logic             code_chg;

  logic [PW-1:0]    pre_cnt;
  logic             tick;

  mode_t            state;
  logic             phase;
  logic             phase_next;
  logic [LED_W-1:0] sel;
  logic [LED_W-1:0] led_next;
`ifdef SWLED_CHASE_EN
  logic [LED_W-1:0] ptr;
  logic [LED_W-1:0] ptr_next;
`endif

  // The button shares the switch synchroniser/debouncer as the top bit.
  assign raw = {btn_mode, sw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_stable  = stable[SW_W-1:0];
  assign btn_stable = stable[SW_W];
  assign btn_rise   = btn_stable & ~btn_prev;
  assign code_chg   = (sw_stable != sw_prev);
  assign sel        = {{(LED_W-1){1'b0}}, 1'b1} << sw_stable;
  // A mode change swallows a coincident tick and restarts the prescaler.
  assign tick       = (pre_cnt == PW'(BLINK_DIV - 1)) && !btn_rise;
  assign mode       = state;

  always_comb begin
    phase_next = phase;
    if (btn_rise)  phase_next = 1'b1;
    else if (tick) phase_next = ~phase;
`ifdef SWLED_CHASE_EN
    ptr_next = ptr;
    if (btn_rise)                         ptr_next = sel;
    else if (state == M_CHASE && code_chg) ptr_next = sel;
    else if (state == M_CHASE && tick)     ptr_next = {ptr[LED_W-2:0], ptr[LED_W-1]};
`endif
    case (state)
      M_BLINK: led_next = phase_next ? sel : '0;
`ifdef SWLED_CHASE_EN
      M_CHASE: led_next = ptr_next;
`endif
      default: led_next = sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= M_STATIC;
      phase       <= 1'b1;
      led         <= '0;
      pre_cnt     <= '0;
      btn_prev    <= 1'b0;
      sw_prev     <= '0;
      code_change <= 1'b0;
`ifdef SWLED_CHASE_EN
      ptr         <= '0;
`endif
    end else begin
      btn_prev    <= btn_stable;
      sw_prev     <= sw_stable;
      code_change <= code_chg;
      phase       <= phase_next;
      led         <= led_next;
`ifdef SWLED_CHASE_EN
      ptr         <= ptr_next;
`endif
      if (btn_rise || tick) pre_cnt <= '0;
      else                  pre_cnt <= pre_cnt + 1'b1;
      if (btn_rise) begin
        case (state)
          M_STATIC: state <= M_BLINK;
`ifdef SWLED_CHASE_EN
          M_BLINK:  state <= M_CHASE;
`else
          M_BLINK:  state <= M_STATIC;
`endif
          default:  state <= M_STATIC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sw_led_mode_ctrl.sv
// Directed self-checking bench for sw_led_mode_ctrl (SW_W=2, DEBOUNCE_CYCLES=4, BLINK_DIV=8).
// Covers whichever build is selected by SWLED_CHASE_EN.
module tb_sw_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw;
  logic       btn_mode;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] sw_stable;
  logic       code_change;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sw_led_mode_ctrl #(
    .SW_W(2),
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn_mode(btn_mode),
    .led(led),
    .mode(mode),
    .sw_stable(sw_stable),
    .code_change(code_change)
  );

  always #5 clk = ~clk;

  // cyc is the index of the last rising edge; sampling happens 1ns after it.
  task step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task stepTo(input int t);
    while (cyc < t) step(1);
  endtask

  task applyStimulus(input logic [1:0] s, input logic b, input logic r);
    sw       = s;
    btn_mode = b;
    rst_n    = r;
  endtask

  task checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    int k;
    int p;
    int q;
    int r;

    applyStimulus(2'b00, 1'b0, 1'b0);
    step(3);
    checkOutput("rst_led", {4'b0, led}, 8'h0);
    checkOutput("rst_mode", {6'b0, mode}, 8'h0);
    checkOutput("rst_sw_stable", {6'b0, sw_stable}, 8'h0);
    checkOutput("rst_code_change", {7'b0, code_change}, 8'h0);

    applyStimulus(2'b00, 1'b0, 1'b1);
    step(1);
    checkOutput("release_led", {4'b0, led}, 8'h1);
    checkOutput("release_mode", {6'b0, mode}, 8'h0);
    checkOutput("release_cc", {7'b0, code_change}, 8'h0);

    // Switch 00 -> 10: stable at k+5, pulse and LED at k+6.
    step(2);
    applyStimulus(2'b10, 1'b0, 1'b1);
    k = cyc + 1;
    stepTo(k + 4);
    checkOutput("sw10_early", {6'b0, sw_stable}, 8'h0);
    stepTo(k + 5);
    checkOutput("sw10_stable", {6'b0, sw_stable}, 8'h2);
    checkOutput("sw10_cc_early", {7'b0, code_change}, 8'h0);
    checkOutput("sw10_led_early", {4'b0, led}, 8'h1);
    stepTo(k + 6);
    checkOutput("sw10_cc", {7'b0, code_change}, 8'h1);
    checkOutput("sw10_led", {4'b0, led}, 8'h4);
    stepTo(k + 7);
    checkOutput("sw10_cc_end", {7'b0, code_change}, 8'h0);
    checkOutput("sw10_led_hold", {4'b0, led}, 8'h4);

    // Three-cycle glitch on bit 0 must be filtered.
    applyStimulus(2'b11, 1'b0, 1'b1);
    step(3);
    applyStimulus(2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      checkOutput("glitch_stable", {6'b0, sw_stable}, 8'h2);
      checkOutput("glitch_cc", {7'b0, code_change}, 8'h0);
    end
    checkOutput("glitch_led", {4'b0, led}, 8'h4);

    applyStimulus(2'b01, 1'b0, 1'b1);
    k = cyc + 1;
    stepTo(k + 6);
    checkOutput("sw01_led", {4'b0, led}, 8'h2);
    checkOutput("sw01_cc", {7'b0, code_change}, 8'h1);
    checkOutput("sw01_stable", {6'b0, sw_stable}, 8'h1);
    step(4);

    // Press 1 held 20 cycles: BLINK, toggling every 8 cycles from mode update at p+6.
    applyStimulus(2'b01, 1'b1, 1'b1);
    p = cyc + 1;
    stepTo(p + 5);
    checkOutput("p1_mode_early", {6'b0, mode}, 8'h0);
    stepTo(p + 6);
    checkOutput("p1_mode", {6'b0, mode}, 8'h1);
    stepTo(p + 7);
    checkOutput("p1_led_on", {4'b0, led}, 8'h2);
    stepTo(p + 13);
    checkOutput("p1_led_on_end", {4'b0, led}, 8'h2);
    stepTo(p + 14);
    checkOutput("p1_led_off", {4'b0, led}, 8'h0);
    stepTo(p + 19);
    applyStimulus(2'b01, 1'b0, 1'b1);
    stepTo(p + 21);
    checkOutput("p1_led_off_end", {4'b0, led}, 8'h0);
    stepTo(p + 22);
    checkOutput("p1_led_on2", {4'b0, led}, 8'h2);
    checkOutput("p1_mode_hold", {6'b0, mode}, 8'h1);
    stepTo(p + 30);
    checkOutput("p1_led_off2", {4'b0, led}, 8'h0);
    stepTo(p + 38);
    checkOutput("p1_led_on3", {4'b0, led}, 8'h2);

    stepTo(p + 40);
    applyStimulus(2'b01, 1'b1, 1'b1);
    q = cyc + 1;
    stepTo(q + 5);
    checkOutput("p2_mode_early", {6'b0, mode}, 8'h1);
`ifdef SWLED_CHASE_EN
    stepTo(q + 6);
    checkOutput("p2_mode_chase", {6'b0, mode}, 8'h2);
    stepTo(q + 7);
    checkOutput("chase_load", {4'b0, led}, 8'h2);
    stepTo(q + 13);
    checkOutput("chase_load_hold", {4'b0, led}, 8'h2);
    stepTo(q + 14);
    checkOutput("chase_step1", {4'b0, led}, 8'h4);
    stepTo(q + 19);
    applyStimulus(2'b01, 1'b0, 1'b1);
    stepTo(q + 22);
    checkOutput("chase_step2", {4'b0, led}, 8'h8);
    stepTo(q + 23);
    applyStimulus(2'b11, 1'b0, 1'b1);
    stepTo(q + 29);
    checkOutput("chase_sw11_stable", {6'b0, sw_stable}, 8'h3);
    checkOutput("chase_pre_reload", {4'b0, led}, 8'h8);
    stepTo(q + 30);
    checkOutput("chase_reload11_cc", {7'b0, code_change}, 8'h1);
    checkOutput("chase_reload11", {4'b0, led}, 8'h8);
    stepTo(q + 37);
    checkOutput("chase_reload11_hold", {4'b0, led}, 8'h8);
    stepTo(q + 38);
    checkOutput("chase_wrap", {4'b0, led}, 8'h1);
    stepTo(q + 46);
    checkOutput("chase_after_wrap", {4'b0, led}, 8'h2);
    stepTo(q + 47);
    applyStimulus(2'b01, 1'b0, 1'b1);
    stepTo(q + 53);
    checkOutput("chase_pre_reload01", {4'b0, led}, 8'h2);
    stepTo(q + 54);
    checkOutput("chase_reload01_cc", {7'b0, code_change}, 8'h1);
    checkOutput("chase_reload01", {4'b0, led}, 8'h2);
    checkOutput("chase_mode_hold", {6'b0, mode}, 8'h2);
    stepTo(q + 62);
    checkOutput("chase_step_after_reload", {4'b0, led}, 8'h4);
    stepTo(q + 64);
    applyStimulus(2'b01, 1'b1, 1'b1);
    r = cyc + 1;
    stepTo(r + 5);
    checkOutput("p3_mode_early", {6'b0, mode}, 8'h2);
    stepTo(r + 6);
    checkOutput("p3_mode_static", {6'b0, mode}, 8'h0);
    stepTo(r + 7);
    checkOutput("p3_led_static", {4'b0, led}, 8'h2);
    stepTo(r + 19);
    applyStimulus(2'b01, 1'b0, 1'b1);
`else
    stepTo(q + 6);
    checkOutput("p2_mode_static", {6'b0, mode}, 8'h0);
    stepTo(q + 7);
    checkOutput("p2_led_static", {4'b0, led}, 8'h2);
    for (int i = 0; i < 11; i++) begin
      step(1);
      checkOutput("p2_mode_hold", {6'b0, mode}, 8'h0);
      checkOutput("p2_led_hold", {4'b0, led}, 8'h2);
    end
    stepTo(q + 19);
    applyStimulus(2'b01, 1'b0, 1'b1);
    stepTo(q + 30);
    applyStimulus(2'b01, 1'b1, 1'b1);
    r = cyc + 1;
    stepTo(r + 5);
    checkOutput("p3_mode_early", {6'b0, mode}, 8'h0);
    stepTo(r + 6);
    checkOutput("p3_mode_blink", {6'b0, mode}, 8'h1);
    stepTo(r + 7);
    checkOutput("p3_led_on", {4'b0, led}, 8'h2);
    stepTo(r + 19);
    applyStimulus(2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(1);
      checkOutput("p3_mode_hold", {6'b0, mode}, 8'h1);
    end
`endif

    // Reset in the middle of a debounce must discard the partial count.
    stepTo(r + 32);
    applyStimulus(2'b10, 1'b0, 1'b1);
    step(3);
    applyStimulus(2'b10, 1'b0, 1'b0);
    step(2);
    checkOutput("rst2_led", {4'b0, led}, 8'h0);
    checkOutput("rst2_mode", {6'b0, mode}, 8'h0);
    checkOutput("rst2_sw_stable", {6'b0, sw_stable}, 8'h0);
    checkOutput("rst2_cc", {7'b0, code_change}, 8'h0);
    applyStimulus(2'b10, 1'b0, 1'b1);
    k = cyc + 1;
    stepTo(k);
    checkOutput("rst2_release_led", {4'b0, led}, 8'h1);
    stepTo(k + 4);
    checkOutput("rst2_no_partial", {6'b0, sw_stable}, 8'h0);
    stepTo(k + 5);
    checkOutput("rst2_stable", {6'b0, sw_stable}, 8'h2);
    stepTo(k + 6);
    checkOutput("rst2_led_new", {4'b0, led}, 8'h4);
    checkOutput("rst2_cc_new", {7'b0, code_change}, 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
